// File: rtl/acorn128_tag_verify.sv
// ACORN-128 decryption-side tag check: runs the finalization steps from the
// post-ciphertext state and compares the last TAG_W keystream bits against
// the received tag. Only the pass/fail verdict ever leaves the block.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; verdict from the last run held on tag_ok
// ST_RUN  | one finalization step per cycle, capturing the last TAG_W ks
// ST_CMP  | constant-time compare, registers verdict and pulses done
module acorn128_tag_verify #(
   parameter int FIN_STEPS = 768,
   parameter int TAG_W     = 128,
   parameter int CNT_W     = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [292:0]       state_in,
   input  logic [TAG_W-1:0]   tag_in,
   output logic               busy,
   output logic               done,
   output logic               tag_ok
);

   localparam int              IDX_W     = $clog2(TAG_W);
   localparam logic [CNT_W-1:0] CAP_START = CNT_W'(FIN_STEPS - TAG_W);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(FIN_STEPS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_CMP
   } state_t;

   state_t             state_q, state_d;
   logic [292:0]       s_q, s_d;
   logic [TAG_W-1:0]   t_q, t_d;
   logic [TAG_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               ok_q, ok_d;

   logic [292:0]       s_fb;
   logic [292:0]       s_step;
   logic               ks;
   logic               fbit;
   logic [IDX_W-1:0]   cap_idx;

   function automatic logic maj(input logic x, input logic y, input logic z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   function automatic logic ch(input logic x, input logic y, input logic z);
      return (x & y) ^ (~x & z);
   endfunction

   // One ACORN state-update step with m=0, ca=1, cb=1. The six feedback
   // updates run from high to low index, so each reads only untouched bits.
   always_comb begin
      s_fb      = s_q;
      s_fb[289] = s_q[289] ^ s_q[235] ^ s_q[230];
      s_fb[230] = s_q[230] ^ s_q[196] ^ s_q[193];
      s_fb[193] = s_q[193] ^ s_q[160] ^ s_q[154];
      s_fb[154] = s_q[154] ^ s_q[111] ^ s_q[107];
      s_fb[107] = s_q[107] ^ s_q[66]  ^ s_q[61];
      s_fb[61]  = s_q[61]  ^ s_q[23]  ^ s_q[0];
      ks   = s_fb[12] ^ s_fb[154] ^ maj(s_fb[235], s_fb[61], s_fb[193])
           ^ ch(s_fb[230], s_fb[111], s_fb[66]);
      fbit = s_fb[0] ^ ~s_fb[107] ^ maj(s_fb[244], s_fb[23], s_fb[160])
           ^ s_fb[196] ^ ks;
      s_step = {fbit, s_fb[292:1]};
   end

   // Next-state and datapath control for IDLE/RUN/CMP.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      t_d     = t_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ok_d    = ok_q;
      cap_idx = IDX_W'(cnt_q - CAP_START);
      unique case (state_q)
         ST_IDLE: begin
            // The state register already reads IDLE while done is high; that
            // cycle still belongs to the finishing run, so start is ignored.
            if (start && !done_q) begin
               s_d     = state_in;
               t_d     = tag_in;
               acc_d   = '0;
               cnt_d   = '0;
               ok_d    = 1'b0;
               busy_d  = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            s_d = s_step;
            if (cnt_q >= CAP_START) begin
               acc_d[cap_idx] = ks;
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
               state_d = ST_CMP;
            end
         end
         ST_CMP: begin
            ok_d    = ~|(acc_q ^ t_q);
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously by rst low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         s_q     <= '0;
         t_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ok_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         t_q     <= t_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ok_q    <= ok_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign tag_ok = ok_q;

endmodule

// File: tb/tb_acorn128_tag_verify.sv
// Bench for acorn128_tag_verify: directed and seeded-random verification runs
// checked against a behavioural ACORN finalization model.
module tb_acorn128_tag_verify;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [292:0] state_in;
   logic [127:0] tag_in;
   logic         busy;
   logic         done;
   logic         tag_ok;

   int total = 0;
   int bad   = 0;

   acorn128_tag_verify dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .state_in (state_in),
      .tag_in   (tag_in),
      .busy     (busy),
      .done     (done),
      .tag_ok   (tag_ok)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] model_tag(input logic [292:0] s_in);
      logic [292:0] s;
      logic [127:0] acc;
      logic         ks;
      logic         f;
      s   = s_in;
      acc = '0;
      for (int i = 0; i < 768; i++) begin
         s[289] = s[289] ^ s[235] ^ s[230];
         s[230] = s[230] ^ s[196] ^ s[193];
         s[193] = s[193] ^ s[160] ^ s[154];
         s[154] = s[154] ^ s[111] ^ s[107];
         s[107] = s[107] ^ s[66]  ^ s[61];
         s[61]  = s[61]  ^ s[23]  ^ s[0];
         ks = s[12] ^ s[154]
            ^ ((s[235] & s[61]) ^ (s[235] & s[193]) ^ (s[61] & s[193]))
            ^ ((s[230] & s[111]) ^ (~s[230] & s[66]));
         f  = s[0] ^ ~s[107]
            ^ ((s[244] & s[23]) ^ (s[244] & s[160]) ^ (s[23] & s[160]))
            ^ s[196] ^ ks;
         s = {f, s[292:1]};
         if (i >= 640) acc = {ks, acc[127:1]};
      end
      return acc;
   endfunction

   function automatic logic [292:0] rand_state();
      logic [319:0] tmp;
      for (int i = 0; i < 10; i++) tmp[i*32 +: 32] = $urandom();
      return tmp[292:0];
   endfunction

   // Runs one verification; pulses start again at cycles pa..pd (sampled at
   // that edge number after the accepting edge) with a different state/tag.
   task automatic do_run(input logic [292:0] s, input logic [127:0] t,
                         input int pa, input int pb, input int pc, input int pd,
                         input int tail,
                         output int done_at, output logic ok, output logic ok0,
                         output logic busy_bad, output logic early_ok,
                         output int done_cnt);
      state_in = s;
      tag_in   = t;
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      state_in = ~s;
      tag_in   = ~t;
      ok0      = tag_ok;
      done_at  = -1;
      ok       = 1'b0;
      busy_bad = (busy !== 1'b1);
      early_ok = 1'b0;
      done_cnt = 0;
      for (int n = 1; n <= 1000; n++) begin
         start = (n == pa) || (n == pb) || (n == pc) || (n == pd);
         @(posedge clk); #1;
         if (done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = n;
               ok      = tag_ok;
            end
         end
         if (done_at < 0) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (tag_ok !== 1'b0) early_ok = 1'b1;
         end else begin
            if (busy !== 1'b0) busy_bad = 1'b1;
            if (tag_ok !== ok) busy_bad = 1'b1;
         end
         if (done_at >= 0 && n >= done_at + tail) break;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst      = 1'b0;
      start    = 1'b0;
      state_in = '0;
      tag_in   = '0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (tag_ok !== 1'b0) begin bad++; $display("FAIL reset_tag_ok got=%b want=0", tag_ok); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_zero_pass();
      int da, dc; logic ok, ok0, bb, eo;
      logic [127:0] g;
      g = model_tag('0);
      do_run('0, g, -1, -1, -1, -1, 2, da, ok, ok0, bb, eo, dc);
      total++; if (da !== 769) begin bad++; $display("FAIL zero_done_latency got=%0d want=769", da); end
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL zero_tag_ok got=%b want=1", ok); end
      total++; if (bb !== 1'b0) begin bad++; $display("FAIL zero_busy_or_hold got=%b want=0", bb); end
      total++; if (eo !== 1'b0) begin bad++; $display("FAIL zero_early_tag_ok got=%b want=0", eo); end
      total++; if (dc !== 1) begin bad++; $display("FAIL zero_done_count got=%0d want=1", dc); end
   endtask

   task automatic test_bit_flips();
      int da, dc; logic ok, ok0, bb, eo;
      logic [127:0] g, t;
      g = model_tag('0);
      t = g; t[0] = ~t[0];
      do_run('0, t, -1, -1, -1, -1, 2, da, ok, ok0, bb, eo, dc);
      total++; if (ok0 !== 1'b0) begin bad++; $display("FAIL flip0_clear_on_accept got=%b want=0", ok0); end
      total++; if (da !== 769 || ok !== 1'b0) begin bad++; $display("FAIL flip0 got done_at=%0d ok=%b want 769/0", da, ok); end
      t = g; t[127] = ~t[127];
      do_run('0, t, -1, -1, -1, -1, 2, da, ok, ok0, bb, eo, dc);
      total++; if (da !== 769 || ok !== 1'b0) begin bad++; $display("FAIL flip127 got done_at=%0d ok=%b want 769/0", da, ok); end
   endtask

   task automatic test_random();
      int da, dc; logic ok, ok0, bb, eo, exp;
      logic [292:0] s;
      logic [127:0] g, t, m;
      void'($urandom(32'h1));
      for (int v = 0; v < 64; v++) begin
         s   = rand_state();
         g   = model_tag(s);
         exp = ((v % 2) == 0);
         m   = 128'd1;
         m   = m << $urandom_range(127, 0);
         t   = exp ? g : (g ^ m);
         do_run(s, t, -1, -1, -1, -1, 1, da, ok, ok0, bb, eo, dc);
         total++;
         if (da !== 769 || ok !== exp) begin
            bad++;
            $display("FAIL random_vec%0d got done_at=%0d ok=%b want 769/%b", v, da, ok, exp);
         end
      end
   endtask

   task automatic test_start_while_busy();
      int da, dc; logic ok, ok0, bb, eo;
      logic [292:0] s;
      logic [127:0] g;
      s = {293{1'b1}};
      g = model_tag(s);
      // Pulses at 10/400 are mid-run, 768 is the final step, 770 is the done cycle.
      do_run(s, g, 10, 400, 768, 770, 10, da, ok, ok0, bb, eo, dc);
      total++; if (da !== 769 || ok !== 1'b1) begin bad++; $display("FAIL busy_start got done_at=%0d ok=%b want 769/1", da, ok); end
      total++; if (dc !== 1) begin bad++; $display("FAIL busy_start_done_count got=%0d want=1", dc); end
      total++; if (bb !== 1'b0) begin bad++; $display("FAIL busy_start_busy got=%b want=0", bb); end
   endtask

   task automatic test_reset_mid_run();
      int da, dc; logic ok, ok0, bb, eo;
      logic [127:0] g;
      g = model_tag('0);
      state_in = '0;
      tag_in   = g;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (300) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL midreset_done got=%b want=0", done); end
      total++; if (tag_ok !== 1'b0) begin bad++; $display("FAIL midreset_tag_ok got=%b want=0", tag_ok); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midreset_idle got busy=%b done=%b want 0/0", busy, done); end
      do_run('0, g, -1, -1, -1, -1, 2, da, ok, ok0, bb, eo, dc);
      total++; if (da !== 769 || ok !== 1'b1) begin bad++; $display("FAIL midreset_rerun got done_at=%0d ok=%b want 769/1", da, ok); end
   endtask

   task automatic test_back_to_back();
      int da, dc; logic ok, ok0, bb, eo;
      logic [127:0] g, t;
      g = model_tag('0);
      t = g; t[64] = ~t[64];
      do_run('0, g, -1, -1, -1, -1, 1, da, ok, ok0, bb, eo, dc);
      total++; if (da !== 769 || ok !== 1'b1) begin bad++; $display("FAIL b2b_first got done_at=%0d ok=%b want 769/1", da, ok); end
      do_run('0, t, -1, -1, -1, -1, 2, da, ok, ok0, bb, eo, dc);
      total++; if (ok0 !== 1'b0) begin bad++; $display("FAIL b2b_clear_on_accept got=%b want=0", ok0); end
      total++; if (da !== 769 || ok !== 1'b0) begin bad++; $display("FAIL b2b_second got done_at=%0d ok=%b want 769/0", da, ok); end
   endtask

   initial begin
      test_reset();
      test_zero_pass();
      test_bit_flips();
      test_start_while_busy();
      test_reset_mid_run();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
